// File: rtl/approx_add_error_recovery.sv
// Checks an approximate adder result against an exact sum built CHUNK bits per cycle,
// returns the corrected value, error flag and distance, and counts erroneous results.
module approx_add_error_recovery #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] approx_sum,
    input  logic             approx_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   exact_sum,
    output logic             err_flag,
    output logic [WIDTH:0]   err_dist,
    output logic [15:0]      err_count,
    input  logic             err_clear
);

    // state | meaning
    // IDLE  | waiting for a bundle, in_ready=1
    // ADD   | adding one CHUNK-bit slice per cycle
    // CMP   | comparing exact vs approximate result
    // DONE  | result presented, waiting for out_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   apx_q, apx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH:0]   exact_q, exact_d;
    logic             err_flag_q, err_flag_d;
    logic [WIDTH:0]   err_dist_q, err_dist_d;
    logic [15:0]      err_count_q, err_count_d;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH:0]   exact_w;
    logic [WIDTH:0]   dist_w;
    logic             handshake;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        apx_d       = apx_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        exact_d     = exact_q;
        err_flag_d  = err_flag_q;
        err_dist_d  = err_dist_q;
        err_count_d = err_count_q;

        // Operands shift right each ADD cycle, so the active slice is always the low CHUNK bits;
        // sum slices enter from the top and land in place after NCHUNK cycles.
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        exact_w   = {carry_q, sum_q};
        dist_w    = (exact_w >= apx_q) ? (exact_w - apx_q) : (apx_q - exact_w);
        handshake = (state_q == DONE) && out_ready;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    apx_d   = {approx_cout, approx_sum};
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
                carry_d = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = CMP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CMP: begin
                exact_d    = exact_w;
                err_flag_d = (exact_w != apx_q);
                err_dist_d = dist_w;
                state_d    = DONE;
            end
            default: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        if (err_clear) begin
            err_count_d = '0;
        end else if (handshake && err_flag_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            apx_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            exact_q     <= '0;
            err_flag_q  <= 1'b0;
            err_dist_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            apx_q       <= apx_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            exact_q     <= exact_d;
            err_flag_q  <= err_flag_d;
            err_dist_q  <= err_dist_d;
            err_count_q <= err_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign exact_sum = exact_q;
    assign err_flag  = err_flag_q;
    assign err_dist  = err_dist_q;
    assign err_count = err_count_q;

endmodule
